maquina_de_cafe_multi: RTL and testbench

Parametrised successor to the single-beverage coffee controller. It accumulates credit from multiple coin denominations and offers N_BEV beverages, each with its own price and stock flag. It brews for a timed interval, then returns change. On cancel, timeout, or a missing ingredient it refunds the full credit. It sits between the coin acceptor, the selection panel and the dispensing hardware.

---
 rtl/mdc_pkg.sv | 36 +++
 rtl/maquina_de_cafe_multi_if.sv | 37 +++
 rtl/mdc_timer.sv | 28 ++
 rtl/maquina_de_cafe_multi.sv | 183 ++++++++++++++++++
 tb/tb_maquina_de_cafe_multi.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mdc_pkg.sv
// Shared types and constants for the multi-beverage coffee controller:
// state/status encoding, coin denominations and price lookup.
package mdc_pkg;

    localparam logic [2:0] STATUS_IDLE   = 3'b000;
    localparam logic [2:0] STATUS_CREDIT = 3'b001;
    localparam logic [2:0] STATUS_BREW   = 3'b010;
    localparam logic [2:0] STATUS_CHANGE = 3'b011;
    localparam logic [2:0] STATUS_REFUND = 3'b100;

    // State encoding equals the status code so status comes straight off the state flops.
    typedef enum logic [2:0] {
        ST_IDLE   = STATUS_IDLE,
        ST_CREDIT = STATUS_CREDIT,
        ST_BREW   = STATUS_BREW,
        ST_CHANGE = STATUS_CHANGE,
        ST_REFUND = STATUS_REFUND
    } state_t;

    localparam int COIN_VAL [0:3] = '{5, 10, 25, 50};

    localparam int MAX_BEV = 8;
    localparam int MAX_W   = 16;

    // Extracts the w-bit price of beverage idx from a packed price vector (idx 0 in LSBs).
    function automatic logic [MAX_W-1:0] price_at(input logic [MAX_BEV*MAX_W-1:0] prices,
                                                  input int idx,
                                                  input int w);
        logic [MAX_BEV*MAX_W-1:0] shifted;
        logic [MAX_W-1:0] mask;
        shifted = prices >> (idx * w);
        mask    = (MAX_W'(1) << w) - MAX_W'(1);
        return shifted[MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/maquina_de_cafe_multi_if.sv
// Panel/coin-acceptor/dispenser signal bundle of the coffee controller.
interface maquina_de_cafe_multi_if #(
    parameter int N_BEV    = 4,
    parameter int CREDIT_W = 8
);
    localparam int IDX_W = $clog2(N_BEV);

    logic                coin_valid;
    logic [1:0]          coin_type;
    logic                sel_valid;
    logic [IDX_W-1:0]    sel_idx;
    logic                cancel;
    logic                water_ok;
    logic [N_BEV-1:0]    stock_ok;

    logic [2:0]          status;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic [IDX_W-1:0]    bev_idx;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;
    logic                coin_reject;
    logic                insufficient;

    modport master (
        output coin_valid, coin_type, sel_valid, sel_idx, cancel, water_ok, stock_ok,
        input  status, credit, dispense, bev_idx, change_valid, change_amt,
               coin_reject, insufficient
    );

    modport slave (
        input  coin_valid, coin_type, sel_valid, sel_idx, cancel, water_ok, stock_ok,
        output status, credit, dispense, bev_idx, change_valid, change_amt,
               coin_reject, insufficient
    );

endinterface

// File: rtl/mdc_timer.sv
// Loadable down-counter with a zero flag; used for brew duration and credit timeout.
module mdc_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over counting; the counter parks at zero instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/maquina_de_cafe_multi.sv
// Multi-beverage coffee controller: coin credit, priced selection, timed brew,
// change on completion and full refund on cancel, timeout or missing ingredient.
module maquina_de_cafe_multi
    import mdc_pkg::*;
#(
    parameter int                        N_BEV          = 4,
    parameter int                        CREDIT_W       = 8,
    parameter logic [N_BEV*CREDIT_W-1:0] PRICES         = {8'd40, 8'd30, 8'd25, 8'd15},
    parameter int                        BREW_CYCLES    = 16,
    parameter int                        TIMEOUT_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    maquina_de_cafe_multi_if.slave bus
);

    localparam int IDX_W  = $clog2(N_BEV);
    localparam int BREW_W = $clog2(BREW_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [MAX_BEV*MAX_W-1:0] PRICE_VEC = (MAX_BEV*MAX_W)'(PRICES);

    state_t              state;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] change_amt_q;
    logic [IDX_W-1:0]    bev_idx_q;
    logic                dispense_q;
    logic                change_valid_q;
    logic                coin_reject_q;
    logic                insufficient_q;

    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic [CREDIT_W-1:0] credit_in;
    logic                sel_in_range;
    logic                sel_stocked;
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W-1:0] brew_price;
    logic                any_event;
    logic                brew_go;
    logic                brew_load;
    logic                brew_en;
    logic                brew_zero;
    logic                to_load;
    logic                to_en;
    logic                to_zero;

    // Credit after this cycle's coin, if it fits; shared by every CREDIT-state outcome.
    assign coin_val     = (CREDIT_W+1)'(COIN_VAL[bus.coin_type]);
    assign coin_sum     = {1'b0, credit_q} + coin_val;
    assign coin_fits    = !coin_sum[CREDIT_W];
    assign credit_in    = (bus.coin_valid && coin_fits) ? coin_sum[CREDIT_W-1:0] : credit_q;

    assign sel_in_range = bus.sel_valid && (int'(bus.sel_idx) < N_BEV);
    assign sel_stocked  = bus.water_ok && bus.stock_ok[bus.sel_idx];
    assign sel_price    = CREDIT_W'(price_at(PRICE_VEC, int'(bus.sel_idx), CREDIT_W));
    assign brew_price   = CREDIT_W'(price_at(PRICE_VEC, int'(bev_idx_q), CREDIT_W));
    assign any_event    = bus.coin_valid || bus.sel_valid || bus.cancel;

    assign brew_go   = !bus.cancel && sel_in_range && sel_stocked && (credit_in >= sel_price);
    assign brew_load = (state == ST_CREDIT) && brew_go;
    assign brew_en   = (state == ST_BREW);
    assign to_load   = ((state == ST_IDLE) && bus.coin_valid) || ((state == ST_CREDIT) && any_event);
    assign to_en     = (state == ST_CREDIT) && !any_event;

    mdc_timer #(.W(BREW_W)) u_brew_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (brew_load),
        .en       (brew_en),
        .load_val (BREW_W'(BREW_CYCLES - 1)),
        .zero     (brew_zero)
    );

    mdc_timer #(.W(TO_W)) u_timeout_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (to_load),
        .en       (to_en),
        .load_val (TO_W'(TIMEOUT_CYCLES - 1)),
        .zero     (to_zero)
    );

    // Controller FSM; every output is a flop updated together with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            credit_q       <= '0;
            change_amt_q   <= '0;
            bev_idx_q      <= '0;
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
        end else begin
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;

            case (state)
                ST_IDLE: begin
                    if (bus.coin_valid) begin
                        if (coin_fits) begin
                            credit_q <= coin_sum[CREDIT_W-1:0];
                            state    <= ST_CREDIT;
                        end else begin
                            coin_reject_q <= 1'b1;
                        end
                    end
                end

                ST_CREDIT: begin
                    if (bus.coin_valid && !coin_fits) begin
                        coin_reject_q <= 1'b1;
                    end
                    if (bus.cancel || (sel_in_range && !sel_stocked)) begin
                        change_valid_q <= 1'b1;
                        change_amt_q   <= credit_in;
                        credit_q       <= '0;
                        state          <= ST_REFUND;
                    end else if (sel_in_range && (credit_in < sel_price)) begin
                        insufficient_q <= 1'b1;
                        credit_q       <= credit_in;
                    end else if (sel_in_range) begin
                        credit_q   <= credit_in - sel_price;
                        bev_idx_q  <= bus.sel_idx;
                        dispense_q <= 1'b1;
                        state      <= ST_BREW;
                    end else if (!any_event && to_zero) begin
                        change_valid_q <= 1'b1;
                        change_amt_q   <= credit_q;
                        credit_q       <= '0;
                        state          <= ST_REFUND;
                    end else begin
                        credit_q <= credit_in;
                    end
                end

                ST_BREW: begin
                    coin_reject_q <= bus.coin_valid;
                    // Losing water aborts the drink, so the customer gets its price back.
                    if (!bus.water_ok) begin
                        dispense_q     <= 1'b0;
                        change_valid_q <= 1'b1;
                        change_amt_q   <= credit_q + brew_price;
                        credit_q       <= '0;
                        state          <= ST_REFUND;
                    end else if (brew_zero) begin
                        dispense_q <= 1'b0;
                        if (credit_q != '0) begin
                            change_valid_q <= 1'b1;
                            change_amt_q   <= credit_q;
                            credit_q       <= '0;
                            state          <= ST_CHANGE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_CHANGE, ST_REFUND: begin
                    coin_reject_q <= bus.coin_valid;
                    state         <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.status       = state;
    assign bus.credit       = credit_q;
    assign bus.dispense     = dispense_q;
    assign bus.bev_idx      = bev_idx_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_amt   = change_amt_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.insufficient = insufficient_q;

endmodule

// File: tb/tb_maquina_de_cafe_multi.sv
// Directed bench for maquina_de_cafe_multi; expected change/refund amounts go
// through a scoreboard queue that is drained whenever change_valid pulses.
module tb_maquina_de_cafe_multi;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   expChange[$];
    int   cnt;

    maquina_de_cafe_multi_if #(.N_BEV(4), .CREDIT_W(8)) bus ();

    maquina_de_cafe_multi #(
        .N_BEV          (4),
        .CREDIT_W       (8),
        .PRICES         ({8'd40, 8'd30, 8'd25, 8'd15}),
        .BREW_CYCLES    (16),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One-cycle pulse on coin/sel/cancel, driven at a falling edge.
    task automatic applyStimulus(input logic cv, input logic [1:0] ct,
                                 input logic sv, input logic [1:0] si, input logic cn);
        bus.coin_valid = cv;
        bus.coin_type  = ct;
        bus.sel_valid  = sv;
        bus.sel_idx    = si;
        bus.cancel     = cn;
        @(negedge clk);
        bus.coin_valid = 1'b0;
        bus.sel_valid  = 1'b0;
        bus.cancel     = 1'b0;
    endtask

    task automatic coin(input logic [1:0] t);
        applyStimulus(1'b1, t, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic sel(input logic [1:0] i);
        applyStimulus(1'b0, 2'd0, 1'b1, i, 1'b0);
    endtask

    task automatic brewCount(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (!bus.dispense) break;
            n++;
            @(negedge clk);
        end
    endtask

    // Change/refund monitor: every pulse must match the oldest expected amount.
    always @(negedge clk) begin
        if (bus.change_valid) begin
            if (expChange.size() == 0) begin
                checkOutput("unexpected_change", 32'(bus.change_amt), 32'hFFFF_FFFF);
            end else begin
                checkOutput("change_amt", 32'(bus.change_amt), 32'(expChange.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        bus.coin_valid = 1'b0;
        bus.coin_type  = 2'd0;
        bus.sel_valid  = 1'b0;
        bus.sel_idx    = 2'd0;
        bus.cancel     = 1'b0;
        bus.water_ok   = 1'b1;
        bus.stock_ok   = 4'hF;

        repeat (3) @(negedge clk);
        checkOutput("rst_status", 32'(bus.status), 0);
        checkOutput("rst_credit", 32'(bus.credit), 0);
        checkOutput("rst_dispense", 32'(bus.dispense), 0);
        checkOutput("rst_change_valid", 32'(bus.change_valid), 0);
        rst = 1'b1;
        @(negedge clk);

        // Out-of-stock selection refunds the credit.
        bus.stock_ok = 4'b1101;
        coin(2'd1);
        checkOutput("oos_credit", 32'(bus.credit), 10);
        checkOutput("oos_status_credit", 32'(bus.status), 1);
        expChange.push_back(10);
        sel(2'd1);
        checkOutput("oos_status_refund", 32'(bus.status), 4);
        checkOutput("oos_credit_cleared", 32'(bus.credit), 0);
        @(negedge clk);
        checkOutput("oos_status_idle", 32'(bus.status), 0);
        bus.stock_ok = 4'hF;

        // 50 units, beverage 2 costs 30: brew 16 cycles then 20 back.
        coin(2'd2);
        coin(2'd2);
        checkOutput("brew_credit_50", 32'(bus.credit), 50);
        expChange.push_back(20);
        sel(2'd2);
        checkOutput("brew_status", 32'(bus.status), 2);
        checkOutput("brew_bev_idx", 32'(bus.bev_idx), 2);
        checkOutput("brew_credit_left", 32'(bus.credit), 20);
        brewCount(cnt);
        checkOutput("brew_cycles", 32'(cnt), 16);
        checkOutput("brew_status_change", 32'(bus.status), 3);
        @(negedge clk);
        checkOutput("brew_status_idle", 32'(bus.status), 0);
        checkOutput("brew_credit_end", 32'(bus.credit), 0);

        // Insufficient credit, then an exact-price brew with no change pulse.
        coin(2'd0);
        sel(2'd0);
        checkOutput("insuf_pulse", 32'(bus.insufficient), 1);
        checkOutput("insuf_credit", 32'(bus.credit), 5);
        checkOutput("insuf_status", 32'(bus.status), 1);
        coin(2'd1);
        checkOutput("insuf_pulse_low", 32'(bus.insufficient), 0);
        checkOutput("exact_credit", 32'(bus.credit), 15);
        sel(2'd0);
        checkOutput("exact_status_brew", 32'(bus.status), 2);
        checkOutput("exact_credit_zero", 32'(bus.credit), 0);
        brewCount(cnt);
        checkOutput("exact_brew_cycles", 32'(cnt), 16);
        checkOutput("exact_status_idle", 32'(bus.status), 0);

        // Credit overflow rejects the coin; cancel refunds everything.
        for (int i = 0; i < 5; i++) coin(2'd3);
        checkOutput("ovf_credit_250", 32'(bus.credit), 250);
        coin(2'd1);
        checkOutput("ovf_reject", 32'(bus.coin_reject), 1);
        checkOutput("ovf_credit_kept", 32'(bus.credit), 250);
        expChange.push_back(250);
        applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        checkOutput("cancel_status", 32'(bus.status), 4);
        @(negedge clk);
        checkOutput("cancel_status_idle", 32'(bus.status), 0);

        // Water lost mid-brew: price added back, full 50 refunded.
        coin(2'd3);
        expChange.push_back(50);
        sel(2'd3);
        checkOutput("water_credit_left", 32'(bus.credit), 10);
        repeat (4) @(negedge clk);
        checkOutput("water_dispense_c5", 32'(bus.dispense), 1);
        bus.water_ok = 1'b0;
        @(negedge clk);
        checkOutput("water_dispense_drop", 32'(bus.dispense), 0);
        checkOutput("water_status_refund", 32'(bus.status), 4);
        bus.water_ok = 1'b1;
        @(negedge clk);
        checkOutput("water_status_idle", 32'(bus.status), 0);

        // Idle timeout refunds after exactly 1000 quiet cycles.
        coin(2'd0);
        expChange.push_back(5);
        cnt = 0;
        while (bus.status != 3'd4 && cnt < 1100) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("timeout_cycles", 32'(cnt), 1000);
        @(negedge clk);
        checkOutput("timeout_status_idle", 32'(bus.status), 0);

        // Asynchronous reset in the middle of a brew.
        coin(2'd3);
        sel(2'd0);
        checkOutput("arst_brewing", 32'(bus.dispense), 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("arst_dispense", 32'(bus.dispense), 0);
        checkOutput("arst_status", 32'(bus.status), 0);
        checkOutput("arst_credit", 32'(bus.credit), 0);
        checkOutput("arst_bev_idx", 32'(bus.bev_idx), 0);
        checkOutput("arst_change_valid", 32'(bus.change_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("arst_status_after", 32'(bus.status), 0);
        checkOutput("sb_empty", 32'(expChange.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
